// File: rtl/hex_date_scheduler_pkg.sv
// Shared constants, state type and helpers
// for the six-digit date display scheduler.
package hex_date_scheduler_pkg;

  localparam int DIGITS   = 6;
  localparam int NIBBLE_W = 4;
  localparam int DATE_W   = 24;
  localparam int CNT_W    = 26;
  localparam int TBL_MAX  = 8;

  localparam int DEF_ROTATE_TICKS   = 50_000_000;
  localparam int DEF_GAP_TICKS      = 5_000_000;
  localparam int DEF_DEBOUNCE_TICKS = 1_000_000;

  typedef enum logic {
    SHOW = 1'b0,
    GAP  = 1'b1
  } state_t;

  // A digit goes dark when its nibble is not a BCD digit.
  function automatic logic [DIGITS-1:0] bcd_blank(
    input logic [DATE_W-1:0] d
  );
    logic [DIGITS-1:0] b;
    b = '0;
    for (int i = 0; i < DIGITS; i++)
      b[i] = (d[i*NIBBLE_W +: NIBBLE_W] > 4'd9);
    return b;
  endfunction

endpackage

// File: rtl/hex_date_scheduler_key_debounce.sv
// One push-button: 2-flop sync, level debounce,
// one-cycle pulse on the debounced press edge.
module key_debounce
  import hex_date_scheduler_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_TICKS - 1);

  logic             meta;
  logic             sync;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Sync, count consecutive mismatches, accept level.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      meta  <= key_n;
      sync  <= meta;
      press <= 1'b0;
      if (sync != level) begin
        if (cnt == LAST) begin
          level <= sync;
          cnt   <= '0;
          press <= ~sync;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/hex_date_scheduler.sv
// Rotates a small table of BCD dates across six
// 7-segment digits, with blank gaps and key control.
module hex_date_scheduler
  import hex_date_scheduler_pkg::*;
#(
  parameter int NUM_ENTRIES    = 4,
  parameter int ROTATE_TICKS   = DEF_ROTATE_TICKS,
  parameter int GAP_TICKS      = DEF_GAP_TICKS,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter logic [23:0] ENTRY0_INIT = 24'h082301,
  parameter logic [23:0] ENTRY1_INIT = 24'h082401
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  key_n,
  input  logic        load_en,
  input  logic [2:0]  load_idx,
  input  logic [23:0] load_data,
  output logic [23:0] hex_val,
  output logic [5:0]  blank,
  output logic [2:0]  cur_idx,
  output logic        auto_mode
);

  localparam logic [2:0] LAST_IDX =
    3'(NUM_ENTRIES - 1);
  localparam logic [3:0] N_ENT = 4'(NUM_ENTRIES);
  localparam logic [CNT_W-1:0] ROT_LAST =
    CNT_W'(ROTATE_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(GAP_TICKS - 1);
  localparam state_t ADV_STATE =
    (GAP_TICKS == 0) ? SHOW : GAP;

  logic [1:0]        press;
  state_t            state;
  state_t            state_n;
  logic [2:0]        idx_n;
  logic              auto_n;
  logic [CNT_W-1:0]  rot_cnt;
  logic [CNT_W-1:0]  rot_n;
  logic [CNT_W-1:0]  gap_cnt;
  logic [CNT_W-1:0]  gap_n;
  logic [23:0]       tbl [TBL_MAX];
  logic              wr_ok;
  logic [23:0]       show_data;

  key_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_key0 (
    .clk   (clk),
    .reset (reset),
    .key_n (key_n[0]),
    .press (press[0])
  );

  key_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_key1 (
    .clk   (clk),
    .reset (reset),
    .key_n (key_n[1]),
    .press (press[1])
  );

  function automatic logic [2:0] step_idx(
    input logic [2:0] i
  );
    return (i == LAST_IDX) ? 3'd0 : i + 3'd1;
  endfunction

  // Next state, index, mode and counters.
  always_comb begin
    state_n = state;
    idx_n   = cur_idx;
    auto_n  = auto_mode;
    rot_n   = rot_cnt;
    gap_n   = gap_cnt;
    unique case (state)
      SHOW: begin
        if (!auto_mode) begin
          rot_n = '0;
        end else if (rot_cnt == ROT_LAST) begin
          idx_n   = step_idx(cur_idx);
          rot_n   = '0;
          gap_n   = '0;
          state_n = ADV_STATE;
        end else begin
          rot_n = rot_cnt + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_n   = '0;
          state_n = SHOW;
        end else begin
          gap_n = gap_cnt + 1'b1;
        end
      end
      default: state_n = SHOW;
    endcase
    if (press[0]) begin
      auto_n = ~auto_mode;
      rot_n  = '0;
    end
    if (press[1]) begin
      idx_n   = step_idx(cur_idx);
      rot_n   = '0;
      gap_n   = '0;
      state_n = ADV_STATE;
    end
  end

  // Table write qualifier and same-cycle bypass.
  always_comb begin
    wr_ok     = load_en && ({1'b0, load_idx} < N_ENT);
    show_data = tbl[idx_n];
    if (wr_ok && (load_idx == idx_n))
      show_data = load_data;
  end

  // FSM and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SHOW;
      cur_idx   <= 3'd0;
      auto_mode <= 1'b1;
      rot_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_n;
      cur_idx   <= idx_n;
      auto_mode <= auto_n;
      rot_cnt   <= rot_n;
      gap_cnt   <= gap_n;
    end
  end

  // Entry table with reset to the initial dates.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TBL_MAX; i++) begin
        if (i == 0)
          tbl[i] <= ENTRY0_INIT;
        else if (i == 1)
          tbl[i] <= ENTRY1_INIT;
        else
          tbl[i] <= 24'h000000;
      end
    end else if (wr_ok) begin
      tbl[load_idx] <= load_data;
    end
  end

  // Display registers driven from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      hex_val <= ENTRY0_INIT;
      blank   <= '0;
    end else if (state_n == GAP) begin
      blank <= 6'h3F;
    end else begin
      hex_val <= show_data;
      blank   <= bcd_blank(show_data);
    end
  end

endmodule
